// File: rtl/pipelined_cla_subtractor.sv
// -----------------------------------------------------------------------------
// pipelined_cla_subtractor
//
// Pipelined N-bit subtractor: diff = (a - b - bin) mod 2^N.
// The subtraction is done as a + ~b + ~bin. The operands are split into
// SEG-bit segments, and one segment is resolved per pipeline stage. Inside a
// segment the carries come from a generate/propagate lookahead. Between
// stages the borrow is registered, so the critical path is one SEG-bit
// lookahead whatever the value of N.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b/bin are valid
//   in_ready   operands are accepted this cycle (low while stalled or in reset)
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  diff/bout/ovf/zero hold a result
//   out_ready  downstream takes the result this cycle
//   diff       (a - b - bin) mod 2^N
//   bout       unsigned borrow out (a < b + bin)
//   ovf        signed overflow of the two's-complement subtraction
//   zero       diff == 0
//
// Latency is N/SEG cycles and throughput is one result per cycle. A stall
// (out_valid && !out_ready) freezes every stage at once, so bubbles are not
// squeezed out.
// -----------------------------------------------------------------------------
module pipelined_cla_subtractor #(
   parameter int N   = 16,
   parameter int SEG = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         bout,
   output logic         ovf,
   output logic         zero
);

   // Keeps the division legal while the parameter check below reports the error.
   localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
   localparam int STAGES   = N / SEG_SAFE;

   if (SEG < 1 || (N % SEG_SAFE) != 0) begin : g_param_check
      $error("pipelined_cla_subtractor: N must be a positive multiple of SEG");
   end

   // One SEG-bit carry-lookahead add. Returns {carry_out, sum}.
   // Every carry is built from flat generate/propagate terms and does not
   // ripple through the previous carry:
   //   c[i] = OR_j( g[j] & p[j+1..i-1] ) | ( p[0..i-1] & cin )
   function automatic logic [SEG_SAFE:0] cla_seg(
      input logic [SEG_SAFE-1:0] x,
      input logic [SEG_SAFE-1:0] y,
      input logic                cin
   );
      logic [SEG_SAFE-1:0] g;
      logic [SEG_SAFE-1:0] p;
      logic [SEG_SAFE:0]   c;
      logic                term;
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = cin;
      for (int i = 1; i <= SEG_SAFE; i++) begin
         c[i] = cin;
         for (int j = 0; j < i; j++) begin
            c[i] = c[i] & p[j];
         end
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int m = j + 1; m < i; m++) begin
               term = term & p[m];
            end
            c[i] = c[i] | term;
         end
      end
      return {c[SEG_SAFE], p ^ c[SEG_SAFE-1:0]};
   endfunction

   // Per-stage pipeline registers. Stage gi has resolved segments 0..gi.
   logic [N-1:0] res_q [STAGES];   // partially resolved difference
   logic [N-1:0] a_q   [STAGES];   // operands; the upper segments are still pending
   logic [N-1:0] b_q   [STAGES];
   logic         brw_q [STAGES];   // active-high borrow out of the last resolved segment
   logic         vld_q [STAGES];
   logic         ovf_q;
   logic         zero_q;
   logic         stall;

   assign stall     = vld_q[STAGES-1] & ~out_ready;
   assign in_ready  = rst_n & ~stall;
   assign out_valid = vld_q[STAGES-1];
   assign diff      = res_q[STAGES-1];
   assign bout      = brw_q[STAGES-1];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [N-1:0]      a_d;
      logic [N-1:0]      b_d;
      logic [N-1:0]      res_in;
      logic              brw_in;
      logic              vld_d;
      logic [N-1:0]      res_d;
      logic [SEG_SAFE:0] seg_sum;
      logic              brw_d;

      if (gi == 0) begin : g_src
         // The first stage works on the live inputs.
         assign a_d    = a;
         assign b_d    = b;
         assign res_in = '0;
         assign brw_in = bin;
         assign vld_d  = in_valid;
      end else begin : g_chain
         assign a_d    = a_q[gi-1];
         assign b_d    = b_q[gi-1];
         assign res_in = res_q[gi-1];
         assign brw_in = brw_q[gi-1];
         assign vld_d  = vld_q[gi-1];
      end

      // a - b - brw == a + ~b + ~brw. A carry out of 0 means a borrow.
      always_comb begin
         seg_sum = cla_seg(a_d[gi*SEG_SAFE +: SEG_SAFE],
                           ~b_d[gi*SEG_SAFE +: SEG_SAFE], ~brw_in);
         brw_d   = ~seg_sum[SEG_SAFE];
         res_d   = res_in;
         res_d[gi*SEG_SAFE +: SEG_SAFE] = seg_sum[SEG_SAFE-1:0];
      end

      // Bubbles still capture data. Only the valid bit separates them.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            res_q[gi] <= '0;
            a_q[gi]   <= '0;
            b_q[gi]   <= '0;
            brw_q[gi] <= 1'b0;
            vld_q[gi] <= 1'b0;
         end else if (!stall) begin
            res_q[gi] <= res_d;
            a_q[gi]   <= a_d;
            b_q[gi]   <= b_d;
            brw_q[gi] <= brw_d;
            vld_q[gi] <= vld_d;
         end
      end

      if (gi == STAGES - 1) begin : g_flags
         // The flags are registered together with the last segment. The
         // outputs therefore come straight from flops and reset to 0.
         logic ovf_d;
         logic zero_d;

         always_comb begin
            ovf_d  = (a_d[N-1] != b_d[N-1]) && (res_d[N-1] != a_d[N-1]);
            zero_d = (res_d == '0);
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (!stall) begin
               ovf_q  <= ovf_d;
               zero_q <= zero_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_subtractor
//
// Directed bench for pipelined_cla_subtractor (N=16, SEG=4, four stages).
// Results are packed as {zero, ovf, bout, diff}. Expected values are either
// hand-computed constants or come from a 17-bit reference subtraction.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_subtractor;
   localparam int N   = 16;
   localparam int SEG = 4;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b1;
   logic         bin       = 1'b0;
   logic [N-1:0] a         = '0;
   logic [N-1:0] b         = '0;
   logic         in_ready;
   logic         out_valid;
   logic [N-1:0] diff;
   logic         bout;
   logic         ovf;
   logic         zero;

   int checks   = 0;
   int failures = 0;
   logic [18:0] exp_q [$];

   pipelined_cla_subtractor #(.N(N), .SEG(SEG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference result: {zero, ovf, bout, diff}
   function automatic logic [18:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic c);
      logic [N:0] w;
      logic       ov;
      w  = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, c};
      ov = (x[N-1] != y[N-1]) && (w[N-1] != x[N-1]);
      return {(w[N-1:0] == '0), ov, w[N], w[N-1:0]};
   endfunction

   function automatic logic [18:0] observed();
      return {zero, ovf, bout, diff};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operand with the exact-latency check: out_valid stays low after
   // edges 1..3, rises after edge 4 and falls again one cycle later.
   task automatic latency_txn(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                              input logic c, input logic [18:0] exp);
      a = x; b = y; bin = c; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      for (int k = 1; k < 4; k++) begin
         check($sformatf("%s_early_valid%0d", tag, k), out_valid, 0);
         tick();
      end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_result"}, observed(), exp);
      $display("txn %s a=%h b=%h bin=%0d -> diff=%h bout=%0d ovf=%0d zero=%0d",
               tag, x, y, c, diff, bout, ovf, zero);
      tick();
      check({tag, "_valid_drop"}, out_valid, 0);
   endtask

   // One operand, result checked whenever it appears (bounded wait).
   task automatic single_txn(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                             input logic c, input logic [18:0] exp);
      int k;
      a = x; b = y; bin = c; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 10) begin
         tick();
         k++;
      end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_result"}, observed(), exp);
      $display("txn %s a=%h b=%h bin=%0d -> diff=%h bout=%0d ovf=%0d zero=%0d",
               tag, x, y, c, diff, bout, ovf, zero);
      tick();
   endtask

   // Stream n random operands. If stall_len > 0, out_ready is held low for
   // stall_len cycles from the first cycle in which out_valid is seen.
   task automatic stream(input string tag, input int n, input int stall_len);
      int          sent = 0, got = 0, cyc = 0, first = -1, last = -1, stall_left = 0;
      bit          stalled = 1'b0;
      bit          acc;
      logic [18:0] snap = '0;
      logic [18:0] e;
      logic [N-1:0] na, nb;
      logic        nbin;
      exp_q.delete();
      na = N'($urandom); nb = N'($urandom); nbin = 1'($urandom_range(0, 1));
      while (got < n && cyc < 80) begin
         if (out_valid && !stalled && stall_len > 0) begin
            stalled    = 1'b1;
            stall_left = stall_len;
            snap       = observed();
         end
         out_ready = (stall_left == 0);
         in_valid  = (sent < n);
         a = na; b = nb; bin = nbin;
         #1;
         if (stall_left > 0) begin
            check({tag, "_in_ready_stall"}, in_ready, 0);
            if (stall_left < stall_len) begin
               check({tag, "_valid_hold"}, out_valid, 1);
               check({tag, "_result_hold"}, observed(), snap);
            end
         end
         if (out_valid && out_ready) begin
            if (first < 0) first = cyc;
            last = cyc;
            check({tag, "_expected_pending"}, exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check($sformatf("%s_result%0d", tag, got), observed(), e);
               $display("txn %s #%0d diff=%h bout=%0d ovf=%0d zero=%0d", tag, got, diff, bout,
                        ovf, zero);
            end
            got++;
         end
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            exp_q.push_back(model(na, nb, nbin));
            sent++;
            na = N'($urandom); nb = N'($urandom); nbin = 1'($urandom_range(0, 1));
         end
         if (stall_left > 0) stall_left--;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check({tag, "_count"}, got, n);
      check({tag, "_leftover"}, exp_q.size(), 0);
      if (stall_len == 0) check({tag, "_contiguous"}, last - first + 1, n);
      tick();
      check({tag, "_no_extra"}, out_valid, 0);
   endtask

   initial begin : main
      bit seen;

      // Reset state
      tick();
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_outputs", observed(), 0);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1);
      tick();

      // Basic subtraction with exact latency
      latency_txn("basic", 16'h1234, 16'h0234, 1'b0, {1'b0, 1'b0, 1'b0, 16'h1000});

      // Wrap below zero, then signed overflow
      single_txn("wrap", 16'h0000, 16'h0001, 1'b0, {1'b0, 1'b0, 1'b1, 16'hFFFF});
      single_txn("ovf", 16'h8000, 16'h0001, 1'b0, {1'b0, 1'b1, 1'b0, 16'h7FFF});

      // Equal operands: borrow ripples through all four segments
      single_txn("eq_bin0", 16'hABCD, 16'hABCD, 1'b0, {1'b1, 1'b0, 1'b0, 16'h0000});
      single_txn("eq_bin1", 16'hABCD, 16'hABCD, 1'b1, {1'b0, 1'b0, 1'b1, 16'hFFFF});

      // Back-to-back throughput
      stream("b2b", 8, 0);

      // Output stall with frozen pipeline
      stream("stall", 6, 5);

      // Reset in the middle of operation
      a = 16'h5555; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
      tick();
      a = 16'h0F0F; b = 16'h00FF; bin = 1'b0;
      tick();
      a = 16'h1000; b = 16'h2000; bin = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("midrst_pre_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_async_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      tick();
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("midrst_no_stale", seen, 0);
      latency_txn("after_rst", 16'h0010, 16'h0001, 1'b1, {1'b0, 1'b0, 1'b0, 16'h000E});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so that the run always ends.
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pipelined_cla_subtractor.md
Name: pipelined_cla_subtractor

Overview:
- Pipelined N-bit unsigned/two's-complement subtractor computing diff = a - b - bin. It is the inverse-direction companion to the team's combinational carry-lookahead adder.
- The operand is split into SEG-bit segments. Each segment is resolved in its own pipeline stage, with the borrow registered between stages, so the critical path stays at one SEG-bit lookahead regardless of N.
- Sits in datapaths that need high-Fmax wide subtraction, with valid/ready flow control on both sides.

Parameters:
- N, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; STAGES = N/SEG (default 4).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input operands valid
- in_ready  output  1  block can accept operands this cycle
- a  input  N  minuend
- b  input  N  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- diff  output  N  (a - b - bin) mod 2^N
- bout  output  1  unsigned borrow out: 1 iff a < b + bin
- ovf  output  1  signed overflow: a[N-1]!=b[N-1] && diff[N-1]!=a[N-1]
- zero  output  1  diff == 0

Behaviour:
- One clock (clk); reset asynchronous active-low (rst_n). All stage valid bits, out_valid, diff, bout, ovf and zero reset to 0. in_ready is 0 during reset.
- Arithmetic per segment k:
  - sum = a_seg + ~b_seg + c_k, where c_0 = ~bin.
  - c_(k+1) = carry out of the segment.
  - Generate/propagate lookahead is used within the segment.
  - bout = ~c_STAGES.
  - The full-width result equals a + ~b + ~bin truncated to N bits.
- Pipeline: STAGES register stages.
  - Stage k holds: resolved diff bits of segments 0..k-1, the registered carry, the unresolved a/b upper segments, the original sign bits a[N-1] and b[N-1], and a valid bit.
  - Stage 1 resolves segment 0 from the live inputs; stage k resolves segment k-1.
  - The final stage drives diff/bout/ovf/zero/out_valid directly from registers, with no combinational path from a/b to the outputs.
- Latency: exactly STAGES cycles from the accepting edge (in_valid && in_ready) to out_valid=1, with no stall. Throughput is one result per cycle.
- Stall: stall = out_valid && !out_ready.
  - While stall=1 every stage, including valid bits, holds its value.
  - in_ready = !stall.
  - Stalls are global, so bubbles are not compressed.
- Bubbles: a stage with valid=0 still captures data, but its valid bit stays 0. Outputs with out_valid=0 are don't-care except immediately after reset, when they are 0.
- Output hold: while out_valid && !out_ready, diff/bout/ovf/zero are stable.
- Simultaneous events:
  - Accept and emit in the same cycle is allowed when out_ready=1.
  - When in_valid=0 the pipeline still advances and inserts a bubble.
- Boundaries:
  - a=b, bin=0 -> diff=0, zero=1, bout=0.
  - Wrap-around below 0 is modulo 2^N with bout=1.
  - bin=1 with a=b -> diff=all ones, bout=1.
- Reset mid-operation: all in-flight results are discarded. out_valid drops asynchronously on rst_n low. The first result after reset release comes from an operand accepted after release.
- Elaboration: N % SEG != 0 or SEG < 1 triggers a generate-time error.

Test Plan:
- Reset, then a=16'h1234, b=16'h0234, bin=0, one pulse on in_valid, out_ready=1 -> out_valid high exactly 4 cycles later; diff=16'h1000, bout=0, ovf=0, zero=0; out_valid low the next cycle.
- a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, bout=1, ovf=0. Then a=16'h8000, b=16'h0001 -> diff=16'h7FFF, bout=0, ovf=1.
- a=b=16'hABCD with bin=0 -> diff=0, zero=1. Same operands with bin=1 -> diff=16'hFFFF, bout=1, zero=0. Both checks cover the borrow crossing all 4 segments.
- Back-to-back 8 random operands with out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching the reference model (a-b-bin).
- Stream of 6 operands; hold out_ready=0 for 5 cycles once out_valid rises -> in_ready=0 and outputs frozen throughout; after release all 6 results arrive in order with none lost or duplicated.
- Accept 3 operands, assert rst_n=0 for 1 cycle mid-flight -> out_valid=0 immediately and no stale result emerges afterwards; a new operand after release yields its correct result after 4 cycles.
